// File: rtl/axi_hp_sched_pkg.sv
// Shared state encoding, default widths and error codes for the AXI HP burst scheduler.
package axi_hp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_LEN_W   = 8;
  localparam int DEF_TIMEOUT = 4096;

  // Completion status reported for a request that asked for zero beats.
  localparam logic ERR_ZERO_LEN = 1'b1;

endpackage

// File: rtl/axi_hp_burst_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, with wrap.
module rr_arbiter
  import axi_hp_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  logic [ID_W-1:0] w_j;

  always_comb begin
    // NOTE: every output gets a default before the search; a cycle with no
    // request would otherwise leave them unassigned and infer latches.
    o_grant = '0;
    o_idx   = '0;
    w_j     = '0;
    // Scan from the farthest offset down so the nearest requester is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_j = ID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_req[w_j]) begin
        o_grant = NUM_REQ'(1) << w_j;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/axi_hp_burst_sched.sv
// Shares one AXI HP burst master among NUM_REQ requesters, one burst at a time,
// with round-robin grants, a WAIT timeout and per-requester completion status.
module axi_hp_burst_sched
  import axi_hp_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  input  logic [NUM_REQ-1:0]          req_wr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          cpl_valid,
  output logic                        cpl_error,
  output logic                        eng_init_txn,
  output logic [ADDR_W-1:0]           eng_addr,
  output logic [LEN_W-1:0]            eng_len,
  output logic                        eng_wr,
  input  logic                        eng_txn_done,
  input  logic                        eng_error,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done_q;
  logic                r_err;
  logic [ADDR_W-1:0]   r_eng_addr;
  logic [LEN_W-1:0]    r_eng_len;
  logic                r_eng_wr;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [LEN_W-1:0]    w_len;
  logic                w_done_edge;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx)
  );

  assign w_len       = req_len[w_gnt_idx*LEN_W +: LEN_W];
  // Only a rising edge completes a burst, so a done level left over from the last burst is ignored.
  assign w_done_edge = eng_txn_done & ~r_done_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_done_q   <= 1'b0;
      r_err      <= 1'b0;
      r_eng_addr <= '0;
      r_eng_len  <= '0;
      r_eng_wr   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values
      // regardless of statement order.
      r_done_q <= eng_txn_done;
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_grant_id <= w_gnt_idx;
            r_ptr      <= (w_gnt_idx == ID_LAST) ? '0 : w_gnt_idx + ID_W'(1);
            r_eng_addr <= req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_eng_len  <= w_len;
            r_eng_wr   <= req_wr[w_gnt_idx];
            if (w_len == '0) begin
              r_err   <= ERR_ZERO_LEN;
              r_state <= RESP;
            end else begin
              r_state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_done_edge) begin
            r_err   <= eng_error;
            r_state <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE) ? w_gnt : '0;
  assign eng_init_txn = (r_state == LAUNCH);
  assign cpl_valid    = (r_state == RESP) ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign cpl_error    = (r_state == RESP) & r_err;
  assign busy         = (r_state != IDLE);
  assign grant_id     = r_grant_id;
  assign eng_addr     = r_eng_addr;
  assign eng_len      = r_eng_len;
  assign eng_wr       = r_eng_wr;

endmodule

// File: tb/tb_axi_hp_burst_sched.sv
// Scoreboard bench for axi_hp_burst_sched: directed stimulus queues expected
// accept/launch/completion events, a negedge monitor pops and compares them.
module tb_axi_hp_burst_sched;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 64;

  typedef enum int {EV_READY, EV_INIT, EV_CPL} ev_kind_t;

  typedef struct {
    ev_kind_t          kind;
    int                id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              wr;
    logic              err;
    int                gap;  // cycles since previous event, -1 = unchecked
  } exp_ev_t;

  logic                      ACLK = 1'b0;
  logic                      ARESETN;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        cpl_valid;
  logic                      cpl_error;
  logic                      eng_init_txn;
  logic [ADDR_W-1:0]         eng_addr;
  logic [LEN_W-1:0]          eng_len;
  logic                      eng_wr;
  logic                      eng_txn_done;
  logic                      eng_error;
  logic                      busy;
  logic [1:0]                grant_id;

  exp_ev_t exp_q[$];
  int      n_vec    = 0;
  int      n_err    = 0;
  int      cyc      = 0;
  int      last_cyc = 0;

  axi_hp_burst_sched #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_wr       (req_wr),
    .req_ready    (req_ready),
    .cpl_valid    (cpl_valid),
    .cpl_error    (cpl_error),
    .eng_init_txn (eng_init_txn),
    .eng_addr     (eng_addr),
    .eng_len      (eng_len),
    .eng_wr       (eng_wr),
    .eng_txn_done (eng_txn_done),
    .eng_error    (eng_error),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                         input logic w);
    req_addr[id*ADDR_W +: ADDR_W] = a;
    req_len[id*LEN_W +: LEN_W]    = l;
    req_wr[id]                    = w;
  endtask

  task automatic push(input ev_kind_t k, input int id, input int gap, input logic err);
    exp_ev_t e;
    e.kind = k;
    e.id   = id;
    e.gap  = gap;
    e.err  = err;
    e.addr = req_addr[id*ADDR_W +: ADDR_W];
    e.len  = req_len[id*LEN_W +: LEN_W];
    e.wr   = req_wr[id];
    exp_q.push_back(e);
  endtask

  // Monitor side: one comparison per observed event.
  task automatic observe(input ev_kind_t k);
    exp_ev_t e;
    logic    bad;
    int      gap;
    n_vec++;
    gap      = cyc - last_cyc;
    last_cyc = cyc;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event %s: unexpected at cycle %0d, ready=%b init=%b cpl=%b, nothing expected",
               k.name(), cyc, req_ready, eng_init_txn, cpl_valid);
      return;
    end
    e   = exp_q.pop_front();
    bad = (k != e.kind) || (e.gap >= 0 && gap != e.gap);
    case (k)
      EV_READY: bad = bad || (req_ready !== (4'b1 << e.id));
      EV_INIT:  bad = bad || (grant_id !== 2'(e.id)) || (eng_addr !== e.addr) ||
                      (eng_len !== e.len) || (eng_wr !== e.wr);
      default:  bad = bad || (cpl_valid !== (4'b1 << e.id)) || (cpl_error !== e.err);
    endcase
    if (bad) begin
      n_err++;
      $display("FAIL event %s: got ready=%b init=%b cpl=%b err=%b gid=%0d addr=%h len=%0d wr=%b gap=%0d; want %s id=%0d addr=%h len=%0d wr=%b err=%b gap=%0d",
               k.name(), req_ready, eng_init_txn, cpl_valid, cpl_error, grant_id, eng_addr,
               eng_len, eng_wr, gap, e.kind.name(), e.id, e.addr, e.len, e.wr, e.err, e.gap);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETN === 1'b1) begin
      if (req_ready !== '0)      observe(EV_READY);
      if (eng_init_txn === 1'b1) observe(EV_INIT);
      if (cpl_valid !== '0)      observe(EV_CPL);
    end
  end

  // Starts in an IDLE cycle, ends in the next IDLE cycle; dw = cycles from init to done.
  task automatic do_burst(input int id, input int dw, input logic err, input int first_gap);
    push(EV_READY, id, first_gap, 1'b0);
    req_valid[id] = 1'b1;
    @(posedge ACLK); #1;
    req_valid[id] = 1'b0;
    if (req_len[id*LEN_W +: LEN_W] == '0) begin
      push(EV_CPL, id, 1, 1'b1);
      @(posedge ACLK); #1;
    end else begin
      push(EV_INIT, id, 1, 1'b0);
      repeat (dw) begin @(posedge ACLK); #1; end
      eng_txn_done = 1'b1;
      eng_error    = err;
      push(EV_CPL, id, dw + 1, err);
      @(posedge ACLK); #1;
      eng_txn_done = 1'b0;
      eng_error    = 1'b0;
      @(posedge ACLK); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"}, 64'(req_ready), 64'h0);
    check({tag, " cpl_valid"}, 64'(cpl_valid), 64'h0);
    check({tag, " cpl_error"}, 64'(cpl_error), 64'h0);
    check({tag, " init_txn"},  64'(eng_init_txn), 64'h0);
    check({tag, " eng_addr"},  64'(eng_addr), 64'h0);
    check({tag, " eng_len"},   64'(eng_len), 64'h0);
    check({tag, " eng_wr"},    64'(eng_wr), 64'h0);
    check({tag, " busy"},      64'(busy), 64'h0);
    check({tag, " grant_id"},  64'(grant_id), 64'h0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN      = 1'b0;
    req_valid    = '0;
    req_addr     = '0;
    req_len      = '0;
    req_wr       = '0;
    eng_txn_done = 1'b0;
    eng_error    = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Single write burst on requester 1; done 50 cycles after init.
    set_req(1, 32'h0000_1000, 8'd16, 1'b1);
    do_burst(1, 50, 1'b0, -1);
    check("t1 eng_addr held", 64'(eng_addr), 64'h1000);
    check("t1 grant_id", 64'(grant_id), 64'd1);

    // Zero-length request on requester 2: error completion, no launch.
    set_req(2, 32'h0000_2200, 8'd0, 1'b0);
    do_burst(2, 0, 1'b1, 1);
    check("t2 busy after", 64'(busy), 64'h0);
    check("t2 grant_id", 64'(grant_id), 64'd2);

    // Reset in IDLE so the round-robin starts from requester 0.
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h0000_A000 + 32'(i * 'h100), 8'd4, 1'(i));
    for (int k = 0; k < 5; k++) begin
      push(EV_READY, k % 4, (k == 0) ? -1 : 1, 1'b0);
      push(EV_INIT,  k % 4, 1, 1'b0);
      push(EV_CPL,   k % 4, 3, 1'b0);
    end
    req_valid = 4'hF;
    ARESETN   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge ACLK); #1;
      repeat (2) begin @(posedge ACLK); #1; end
      eng_txn_done = 1'b1;
      @(posedge ACLK); #1;
      eng_txn_done = 1'b0;
      @(posedge ACLK); #1;
    end
    req_valid = '0;

    // Timeout on requester 1 (pointer now 1), then requester 2 is served.
    set_req(1, 32'h0000_2000, 8'd8, 1'b0);
    set_req(2, 32'h0000_3000, 8'd32, 1'b1);
    push(EV_READY, 1, -1, 1'b0);
    push(EV_INIT,  1, 1, 1'b0);
    push(EV_CPL,   1, TIMEOUT + 1, 1'b1);
    push(EV_READY, 2, 1, 1'b0);
    push(EV_INIT,  2, 1, 1'b0);
    push(EV_CPL,   2, 4, 1'b0);
    req_valid = 4'b0110;
    @(posedge ACLK); #1;
    req_valid[1] = 1'b0;
    repeat (66) begin @(posedge ACLK); #1; end
    @(posedge ACLK); #1;
    req_valid[2] = 1'b0;
    repeat (3) begin @(posedge ACLK); #1; end
    eng_txn_done = 1'b1;
    @(posedge ACLK); #1;
    eng_txn_done = 1'b0;
    @(posedge ACLK); #1;

    // Stale done level on requester 3: only a fresh rising edge completes.
    set_req(3, 32'h0000_4000, 8'd2, 1'b1);
    eng_txn_done = 1'b1;
    @(posedge ACLK); #1;
    push(EV_READY, 3, -1, 1'b0);
    push(EV_INIT,  3, 1, 1'b0);
    push(EV_CPL,   3, 12, 1'b1);
    req_valid[3] = 1'b1;
    @(posedge ACLK); #1;
    req_valid[3] = 1'b0;
    repeat (10) begin @(posedge ACLK); #1; end
    check("t5 busy with stale done", 64'(busy), 64'h1);
    check("t5 no early cpl", 64'(cpl_valid), 64'h0);
    eng_txn_done = 1'b0;
    @(posedge ACLK); #1;
    eng_txn_done = 1'b1;
    eng_error    = 1'b1;
    @(posedge ACLK); #1;
    eng_txn_done = 1'b0;
    eng_error    = 1'b0;
    @(posedge ACLK); #1;

    // Reset during WAIT of requester 1 (pointer would move to 2).
    set_req(1, 32'h0000_5000, 8'd4, 1'b0);
    push(EV_READY, 1, -1, 1'b0);
    push(EV_INIT,  1, 1, 1'b0);
    req_valid[1] = 1'b1;
    @(posedge ACLK); #1;
    req_valid[1] = 1'b0;
    repeat (5) begin @(posedge ACLK); #1; end
    check("t6 busy in WAIT", 64'(busy), 64'h1);
    #2 ARESETN = 1'b0;
    #1;
    check_all_zero("async reset");
    set_req(2, 32'h0000_6000, 8'd6, 1'b1);
    push(EV_READY, 1, -1, 1'b0);
    push(EV_INIT,  1, 1, 1'b0);
    push(EV_CPL,   1, 3, 1'b0);
    push(EV_READY, 2, 1, 1'b0);
    push(EV_INIT,  2, 1, 1'b0);
    push(EV_CPL,   2, 3, 1'b0);
    req_valid = 4'b0110;
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge ACLK); #1;
      req_valid[k] = 1'b0;
      repeat (2) begin @(posedge ACLK); #1; end
      eng_txn_done = 1'b1;
      @(posedge ACLK); #1;
      eng_txn_done = 1'b0;
      @(posedge ACLK); #1;
    end

    repeat (3) @(posedge ACLK);
    #1;
    check("expected events left", 64'(exp_q.size()), 64'd0);
    check("final busy", 64'(busy), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
